// File: rtl/afg_seq_pkg.sv
// Shared types and defaults for the AFG waveform playback sequencer.
package afg_seq_pkg;

  localparam int ADDR_W_DEF  = 14;
  localparam int BURST_W_DEF = 16;
  localparam int DIV_W_DEF   = 16;
  localparam int BURST_CONT  = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_RUN      = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_LOW = 3'd4
  } seq_state_e;

endpackage

// File: rtl/rate_tick_gen.sv
// Loadable down-counter: while enabled, emits one tick every div_i+1 clocks
// and reloads itself from div_i on each tick.
module rate_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? div_i : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/waveform_playback_sequencer.sv
// Steps the waveform RAM read address Start..Stop at a divided rate for a
// programmed number of passes while the trigger level is held high.
module waveform_playback_sequencer
  import afg_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Trig_Ctrl_Sin,
  input  logic [ADDR_W-1:0]  Start_Addr_Vin,
  input  logic [ADDR_W-1:0]  Stop_Addr_Vin,
  input  logic [BURST_W-1:0] Burst_Vin,
  input  logic [DIV_W-1:0]   Rate_Div_Vin,
  output logic [ADDR_W-1:0]  Mem_Addr_out,
  output logic               Mem_Rd_EN,
  output logic               Ending_Sout,
  output logic               Busy_out,
  output logic [BURST_W-1:0] Burst_Done_out,
  output logic [2:0]         State_Dbg_out
);

  seq_state_e         state_q, state_d;
  logic               trig_q, trig_prev_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rd_en_q, rd_en_d;
  logic [BURST_W-1:0] done_q, done_d;
  logic [ADDR_W-1:0]  start_q, start_d, stop_q, stop_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               start_cond;
  logic               div_load, div_en, tick;
  logic [DIV_W-1:0]   div_src;

  // Rising edge of the registered trigger level.
  assign start_cond = trig_q && !trig_prev_q;

  assign div_load = (state_q == ST_ARM) && trig_q;
  assign div_en   = (state_q == ST_RUN);
  assign div_src  = (state_q == ST_ARM) ? Rate_Div_Vin : div_q;

  rate_tick_gen #(.DIV_W(DIV_W)) u_rate (
    .clk_i   (Clock),
    .rst_n_i (Reset_n),
    .load_i  (div_load),
    .en_i    (div_en),
    .div_i   (div_src),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    done_d  = done_q;
    start_d = start_q;
    stop_d  = stop_q;
    burst_d = burst_q;
    div_d   = div_q;
    case (state_q)
      ST_IDLE: begin
        if (start_cond) begin
          state_d = ST_ARM;
          done_d  = '0;
        end
      end
      ST_ARM: begin
        if (!trig_q) begin
          state_d = ST_IDLE;
        end else begin
          // A reversed range collapses to a single-sample waveform at Start.
          start_d = Start_Addr_Vin;
          stop_d  = (Stop_Addr_Vin < Start_Addr_Vin) ? Start_Addr_Vin : Stop_Addr_Vin;
          burst_d = Burst_Vin;
          div_d   = Rate_Div_Vin;
          addr_d  = Start_Addr_Vin;
          rd_en_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!trig_q) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (addr_q < stop_q) begin
            addr_d  = addr_q + 1'b1;
            rd_en_d = 1'b1;
          end else if (burst_q == BURST_W'(BURST_CONT)) begin
            if (done_q != '1) done_d = done_q + 1'b1;
            addr_d  = start_q;
            rd_en_d = 1'b1;
          end else begin
            done_d = done_q + 1'b1;
            if ((done_q + 1'b1) == burst_q) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = start_q;
              rd_en_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!trig_q) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      done_q      <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      burst_q     <= '0;
      div_q       <= '0;
    end else begin
      state_q     <= state_d;
      trig_q      <= Trig_Ctrl_Sin;
      trig_prev_q <= trig_q;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      done_q      <= done_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      burst_q     <= burst_d;
      div_q       <= div_d;
    end
  end

  assign Mem_Addr_out   = addr_q;
  assign Mem_Rd_EN      = rd_en_q;
  assign Ending_Sout    = (state_q == ST_DONE);
  assign Busy_out       = (state_q == ST_ARM) || (state_q == ST_RUN);
  assign Burst_Done_out = done_q;
  assign State_Dbg_out  = state_q;

endmodule

// File: tb/tb_waveform_playback_sequencer.sv
// Randomized and directed bench for the waveform playback sequencer with a
// cycle-stamped event scoreboard.
module tb_waveform_playback_sequencer;
  import afg_seq_pkg::*;

  localparam int ADDR_W  = 14;
  localparam int BURST_W = 16;
  localparam int DIV_W   = 16;
  localparam int EW      = 49;  // {is_ending, cycle[31:0], data[15:0]}
  localparam int NO_LIM  = 32'h7fff_ffff;

  logic               Clock = 1'b0;
  logic               Reset_n;
  logic               Trig_Ctrl_Sin;
  logic [ADDR_W-1:0]  Start_Addr_Vin;
  logic [ADDR_W-1:0]  Stop_Addr_Vin;
  logic [BURST_W-1:0] Burst_Vin;
  logic [DIV_W-1:0]   Rate_Div_Vin;
  logic [ADDR_W-1:0]  Mem_Addr_out;
  logic               Mem_Rd_EN;
  logic               Ending_Sout;
  logic               Busy_out;
  logic [BURST_W-1:0] Burst_Done_out;
  logic [2:0]         State_Dbg_out;

  logic [EW-1:0] exp_q[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  waveform_playback_sequencer #(
    .ADDR_W(ADDR_W), .BURST_W(BURST_W), .DIV_W(DIV_W)
  ) dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .Trig_Ctrl_Sin  (Trig_Ctrl_Sin),
    .Start_Addr_Vin (Start_Addr_Vin),
    .Stop_Addr_Vin  (Stop_Addr_Vin),
    .Burst_Vin      (Burst_Vin),
    .Rate_Div_Vin   (Rate_Div_Vin),
    .Mem_Addr_out   (Mem_Addr_out),
    .Mem_Rd_EN      (Mem_Rd_EN),
    .Ending_Sout    (Ending_Sout),
    .Busy_out       (Busy_out),
    .Burst_Done_out (Burst_Done_out),
    .State_Dbg_out  (State_Dbg_out)
  );

  // Clock and cycle stamp
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d vectors, required completion", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: pass p, sample i is strobed at t0 + (p*len+i)*(div+1); the
  // wrap closing pass p falls one period after its last sample. Only events
  // at or before lim survive a trigger drop or reset.
  task automatic model_run(input int st, input int len, input int bu, input int dv,
                           input int t0, input int lim, output int nwrap, output int tend);
    int p, t;
    bit fin;
    nwrap = 0; tend = -1; p = 0; fin = 1'b0;
    while (!fin) begin
      for (int i = 0; i < len; i++) begin
        t = t0 + (p * len + i) * (dv + 1);
        if (t <= lim) exp_q.push_back({1'b0, 32'(t), 16'(st + i)});
      end
      t = t0 + (p + 1) * len * (dv + 1);
      if (t > lim) begin
        fin = 1'b1;
      end else begin
        nwrap++;
        if (bu != 0 && nwrap == bu) begin
          exp_q.push_back({1'b1, 32'(t), 16'(bu)});
          tend = t;
          fin  = 1'b1;
        end
      end
      p++;
    end
  endtask

  // Monitor: every strobe or ending pulse must match the next expected event.
  always @(negedge Clock) begin
    logic [EW-1:0] act, e;
    if (Mem_Rd_EN || Ending_Sout) begin
      act = {Ending_Sout, 32'(cyc), Ending_Sout ? Burst_Done_out : 16'(Mem_Addr_out)};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: got %0h required none", act);
      end else begin
        e = exp_q.pop_front();
        check("event", 64'(act), 64'(e));
      end
      if (Ending_Sout) check("busy_on_end", 64'(Busy_out), 64'd0);
    end
  end

  // Raise the trigger with the given program. hold>0 drops the pin hold
  // cycles later; otherwise the run completes (bu must be nonzero).
  task automatic run_seq(input int st, input int sp, input int bu, input int dv,
                         input int hold, input bit keep_high);
    int k, eff, lim, nwrap, tend;
    @(negedge Clock);
    Start_Addr_Vin = ADDR_W'(st);
    Stop_Addr_Vin  = ADDR_W'(sp);
    Burst_Vin      = BURST_W'(bu);
    Rate_Div_Vin   = DIV_W'(dv);
    Trig_Ctrl_Sin  = 1'b1;
    k   = cyc;
    eff = (sp < st) ? st : sp;
    lim = (hold > 0) ? k + hold + 1 : NO_LIM;
    model_run(st, eff - st + 1, bu, dv, k + 3, lim, nwrap, tend);
    if (hold > 0) begin
      repeat (hold) @(negedge Clock);
      Trig_Ctrl_Sin = 1'b0;
      repeat (2) @(negedge Clock);
      if (tend == lim) @(negedge Clock);
      check("abort_state", 64'(State_Dbg_out), 64'(ST_IDLE));
      check("abort_rd_en", 64'(Mem_Rd_EN), 64'd0);
      check("abort_done_cnt", 64'(Burst_Done_out), 64'(nwrap));
    end else begin
      while (cyc < tend + 1) @(negedge Clock);
      check("wait_state", 64'(State_Dbg_out), 64'(ST_WAIT_LOW));
      check("wait_busy", 64'(Busy_out), 64'd0);
      check("wait_addr", 64'(Mem_Addr_out), 64'(eff));
      check("done_cnt", 64'(Burst_Done_out), 64'(bu));
      if (!keep_high) begin
        Trig_Ctrl_Sin = 1'b0;
        repeat (2) @(negedge Clock);
        check("idle_state", 64'(State_Dbg_out), 64'(ST_IDLE));
        check("done_held", 64'(Burst_Done_out), 64'(bu));
      end
    end
    check("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int k, nw, te, st, sp;
    Reset_n = 1'b0;
    Trig_Ctrl_Sin = 1'b0;
    Start_Addr_Vin = '0;
    Stop_Addr_Vin = '0;
    Burst_Vin = '0;
    Rate_Div_Vin = '0;
    repeat (3) @(negedge Clock);
    check("rst_addr", 64'(Mem_Addr_out), 64'd0);
    check("rst_rd_en", 64'(Mem_Rd_EN), 64'd0);
    check("rst_end", 64'(Ending_Sout), 64'd0);
    check("rst_busy", 64'(Busy_out), 64'd0);
    check("rst_done", 64'(Burst_Done_out), 64'd0);
    check("rst_state", 64'(State_Dbg_out), 64'(ST_IDLE));
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock);

    // Directed programs
    run_seq(4, 7, 2, 0, 0, 1'b0);
    run_seq(0, 1, 1, 3, 0, 1'b0);
    run_seq(10, 12, 0, 0, 21, 1'b0);
    run_seq(9, 3, 3, 0, 0, 1'b0);

    // Reset while strobing address 5
    @(negedge Clock);
    Start_Addr_Vin = 14'd0; Stop_Addr_Vin = 14'd9; Burst_Vin = '0; Rate_Div_Vin = '0;
    Trig_Ctrl_Sin = 1'b1;
    k = cyc;
    model_run(0, 10, 0, 0, k + 3, k + 8, nw, te);
    while (cyc < k + 8) @(negedge Clock);
    check("pre_rst_addr", 64'(Mem_Addr_out), 64'd5);
    Reset_n = 1'b0;
    Trig_Ctrl_Sin = 1'b0;
    @(negedge Clock);
    check("mid_rst_addr", 64'(Mem_Addr_out), 64'd0);
    check("mid_rst_rd_en", 64'(Mem_Rd_EN), 64'd0);
    check("mid_rst_busy", 64'(Busy_out), 64'd0);
    check("mid_rst_done", 64'(Burst_Done_out), 64'd0);
    check("mid_rst_state", 64'(State_Dbg_out), 64'(ST_IDLE));
    Reset_n = 1'b1;
    run_seq(3, 5, 1, 0, 0, 1'b0);

    // Held trigger after completion must not re-arm on new inputs
    run_seq(20, 21, 1, 0, 0, 1'b1);
    Start_Addr_Vin = 14'd30;
    repeat (10) @(negedge Clock);
    check("no_rearm_state", 64'(State_Dbg_out), 64'(ST_WAIT_LOW));
    Trig_Ctrl_Sin = 1'b0;
    run_seq(30, 33, 1, 1, 0, 1'b0);

    // Randomized programs, half of them aborted at a random point
    for (int n = 0; n < 12; n++) begin
      st = $urandom_range(0, 40);
      sp = $urandom_range(0, 45);
      if ($urandom_range(0, 1) == 1)
        run_seq(st, sp, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 40), 1'b0);
      else
        run_seq(st, sp, $urandom_range(1, 3), $urandom_range(0, 3), 0, 1'b0);
      repeat ($urandom_range(1, 4)) @(negedge Clock);
    end

    repeat (3) @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
